// File: rtl/btn_cmd_pkg.sv
// btn_cmd_pkg: shared command type and width helper for the button command queue.
// cmd_t is sized for the default build (3 buttons, 8-bit byte position).
package btn_cmd_pkg;

  localparam int NUM_BTN_DEF = 3;
  localparam int POS_W_DEF   = 8;

  // Width of a button index field; never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  localparam int IDX_W_DEF = idx_w(NUM_BTN_DEF);

  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic [POS_W_DEF-1:0] pos;
  } cmd_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, debounce filter and press pulses for one button.
// risePulse is a one-cycle strobe on the edge after the filtered level goes high.
// With BTN_AUTOREPEAT_EN defined, repeatPulse strobes every REPEAT_CYCLES cycles
// while the filtered level stays high; otherwise it is tied low.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic risePulse,
  output logic repeatPulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             syncMeta;
  logic             syncLevel;
  logic             stableLevel;
  logic [CNT_W-1:0] dbCnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncMeta  <= 1'b0;
      syncLevel <= 1'b0;
    end else begin
      syncMeta  <= btnRaw;
      syncLevel <= syncMeta;
    end
  end

  // Accept a new level only after it has disagreed with the stable level long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbCnt       <= '0;
      stableLevel <= 1'b0;
      risePulse   <= 1'b0;
    end else begin
      risePulse <= 1'b0;
      if (syncLevel == stableLevel) begin
        dbCnt <= '0;
      end else if (dbCnt == CNT_LAST) begin
        dbCnt       <= '0;
        stableLevel <= syncLevel;
        risePulse   <= syncLevel;
      end else begin
        dbCnt <= dbCnt + 1'b1;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] repCnt;

  // Count held cycles and re-fire a press every repeat period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      repCnt      <= '0;
      repeatPulse <= 1'b0;
    end else begin
      repeatPulse <= 1'b0;
      if (!stableLevel) begin
        repCnt <= '0;
      end else if (repCnt == REP_LAST) begin
        repCnt      <= '0;
        repeatPulse <= 1'b1;
      end else begin
        repCnt <= repCnt + 1'b1;
      end
    end
  end
`else
  // No autorepeat hardware; the period stays referenced so both builds share one parameter list.
  assign repeatPulse = 1'b0 & (REPEAT_CYCLES > 0);
`endif

endmodule

// File: rtl/btn_cmd_queue.sv
// btn_cmd_queue: debounced push-buttons turned into queued {index, byte position}
// commands for the processor, delivered over a valid/ready handshake.
// Optional feature macro: BTN_AUTOREPEAT_EN (held buttons re-issue presses).
// The FIFO is first-word-fall-through; the head is kept in a register so that
// cmd_idx/cmd_pos hold their last value once the queue empties.
module btn_cmd_queue
  import btn_cmd_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int POS_W           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BTN-1:0]            btn,
  input  logic [POS_W-1:0]              byte_pos,
  input  logic                          cmd_ready,
  output logic                          cmd_valid,
  output logic [idx_w(NUM_BTN)-1:0]     cmd_idx,
  output logic [POS_W-1:0]              cmd_pos,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int IDX_W = idx_w(NUM_BTN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [POS_W-1:0] pos;
  } entry_t;

  logic [NUM_BTN-1:0] risePulse;
  logic [NUM_BTN-1:0] repeatPulse;
  logic [NUM_BTN-1:0] pressPulse;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pushMask;
  logic [NUM_BTN-1:0] clrMask;
  logic [IDX_W-1:0]   pushIdx;

  logic               popEn;
  logic               pushEn;
  logic               hasSpace;
  entry_t             pushEntry;
  entry_t             headEntry;
  entry_t             fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   nextRdPtr;
  logic [CNT_W-1:0]   nextCount;

  for (genvar i = 0; i < NUM_BTN; i++) begin : genBtn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) uDebounce (
      .clk         (clk),
      .rst         (rst),
      .btnRaw      (btn[i]),
      .risePulse   (risePulse[i]),
      .repeatPulse (repeatPulse[i])
    );
  end

  assign pressPulse = risePulse | repeatPulse;

  // Fixed-priority pick of the lowest pending button.
  always_comb begin
    pushIdx  = '0;
    pushMask = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pushIdx  = IDX_W'(i);
        pushMask = NUM_BTN'(1) << i;
      end
    end
  end

  assign cmd_valid     = (fifo_count != '0);
  assign popEn         = cmd_valid & cmd_ready;
  assign hasSpace      = (fifo_count != FULL_CNT) | popEn;
  assign pushEn        = (pending != '0) & hasSpace;
  assign clrMask       = pushMask & {NUM_BTN{pushEn}};
  assign pushEntry.idx = pushIdx;
  assign pushEntry.pos = byte_pos;

  assign nextCount = fifo_count + CNT_W'(pushEn) - CNT_W'(popEn);
  assign nextRdPtr = rdPtr + PTR_W'(popEn);

  // Collect presses; a new press wins over the clear of a bit being pushed, a press
  // landing on a still-waiting bit is merged and flagged as lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~clrMask) | pressPulse;
      if ((pressPulse & pending & ~clrMask) != '0) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      fifoMem[wrPtr] <= pushEntry;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together keep the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
    end else begin
      if (pushEn) begin
        wrPtr <= wrPtr + 1'b1;
      end
      rdPtr      <= nextRdPtr;
      fifo_count <= nextCount;
    end
  end

  // Head register: the entry becoming head next cycle, bypassing the array when the
  // queue would otherwise be empty; held unchanged while the queue is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headEntry <= '0;
    end else if (nextCount != '0) begin
      if (fifo_count == CNT_W'(popEn)) begin
        headEntry <= pushEntry;
      end else begin
        headEntry <= fifoMem[nextRdPtr];
      end
    end
  end

  assign cmd_idx = headEntry.idx;
  assign cmd_pos = headEntry.pos;

endmodule

// File: tb/tb_btn_cmd_queue.sv
// tb_btn_cmd_queue: directed and randomized checks of btn_cmd_queue against a
// queue-based reference model of button presses and command delivery.
module tb_btn_cmd_queue;

  localparam int NB    = 3;
  localparam int DB    = 4;
  localparam int DEPTH = 4;
  localparam int REP   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] btn = '0;
  logic [7:0] bytePos = '0;
  logic       cmdReady = 1'b0;
  logic       cmdValid;
  logic [1:0] cmdIdx;
  logic [7:0] cmdPos;
  logic [2:0] fifoCount;
  logic       overflow;

  int passCnt  = 0;
  int checkCnt = 0;

  typedef struct {
    int idx;
    int pos;
  } cmd_s;

  // reference model state
  cmd_s modelQ[$];
  bit   mSync0[NB];
  bit   mSync1[NB];
  bit   mStable[NB];
  int   mRun[NB];
  int   mSince[NB];
  bit   mPress[NB];
  bit   mPend[NB];
  bit   mOvf;
  int   lastIdx;
  int   lastPos;

  cmd_s popped[$];
  int   holdLeft[NB];
  int   lat;
  bit   sawHigh;
  int   idx1Cnt;

  always #5 clk = ~clk;

  btn_cmd_queue #(
    .NUM_BTN         (NB),
    .POS_W           (8),
    .DEBOUNCE_CYCLES (DB),
    .FIFO_DEPTH      (DEPTH),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .byte_pos   (bytePos),
    .cmd_ready  (cmdReady),
    .cmd_valid  (cmdValid),
    .cmd_idx    (cmdIdx),
    .cmd_pos    (cmdPos),
    .fifo_count (fifoCount),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic modelReset();
    modelQ.delete();
    for (int i = 0; i < NB; i++) begin
      mSync0[i] = 0; mSync1[i] = 0; mStable[i] = 0;
      mRun[i] = 0; mSince[i] = 0; mPress[i] = 0; mPend[i] = 0;
    end
    mOvf = 0;
    lastIdx = 0;
    lastPos = 0;
  endtask

  // One clock edge of the behavioural model, computed from pre-edge values.
  task automatic modelEdge();
    bit doPop;
    bit doPush;
    bit cleared;
    int pick;
    bit newPress[NB];
    doPop = (modelQ.size() > 0) && cmdReady;
    pick = -1;
    for (int i = 0; i < NB; i++) if (mPend[i] && pick < 0) pick = i;
    doPush = (pick >= 0) && ((modelQ.size() < DEPTH) || doPop);
    for (int i = 0; i < NB; i++) begin
      cleared = doPush && (pick == i);
      if (mPress[i] && mPend[i] && !cleared) mOvf = 1;
      mPend[i] = (mPend[i] && !cleared) || mPress[i];
    end
    if (doPop) void'(modelQ.pop_front());
    if (doPush) modelQ.push_back('{pick, int'(bytePos)});
    for (int i = 0; i < NB; i++) begin
      newPress[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
      if (mStable[i]) begin
        mSince[i]++;
        if (mSince[i] == REP) begin
          newPress[i] = 1;
          mSince[i] = 0;
        end
      end else begin
        mSince[i] = 0;
      end
`endif
      // a level is accepted after DB consecutive disagreeing synchronised samples
      if (mSync1[i] != mStable[i]) begin
        mRun[i]++;
        if (mRun[i] == DB) begin
          mStable[i] = mSync1[i];
          mRun[i] = 0;
          if (mStable[i]) newPress[i] = 1;
        end
      end else begin
        mRun[i] = 0;
      end
      mSync1[i] = mSync0[i];
      mSync0[i] = btn[i];
      mPress[i] = newPress[i];
    end
    if (modelQ.size() > 0) begin
      lastIdx = modelQ[0].idx;
      lastPos = modelQ[0].pos;
    end
  endtask

  // Model tracks the DUT clock and asynchronous reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) modelReset();
    else modelEdge();
  end

  task automatic checkModel();
    check("valid", cmdValid, 32'(modelQ.size() != 0));
    check("count", fifoCount, modelQ.size());
    check("overflow", overflow, 32'(mOvf));
    check("head_idx", cmdIdx, lastIdx);
    check("head_pos", cmdPos, lastPos);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      if (cmdValid && cmdReady) popped.push_back('{int'(cmdIdx), int'(cmdPos)});
      @(negedge clk);
      checkModel();
    end
  endtask

  task automatic press(input int b, input int pos);
    bytePos = 8'(pos);
    btn[b] = 1'b1;
    step(6);
    btn[b] = 1'b0;
    step(8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid", cmdValid, 0);
    check("rst_idx", cmdIdx, 0);
    check("rst_pos", cmdPos, 0);
    check("rst_count", fifoCount, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    step(3);

    // single press latency
    bytePos = 8'd50;
    cmdReady = 1'b0;
    btn = 3'b100;
    lat = 0;
    while (!cmdValid && lat < 20) begin
      step();
      lat++;
    end
    check("latency", lat - 1, 7);
    check("lat_idx", cmdIdx, 2);
    check("lat_pos", cmdPos, 50);
    check("lat_count", fifoCount, 1);
    btn = 3'b000;
    step(10);
    check("release_nocmd", fifoCount, 1);
    popped.delete();
    cmdReady = 1'b1;
    step();
    cmdReady = 1'b0;
    step(2);
    check("pop_one_n", popped.size(), 1);
    check("pop_one_idx", (popped.size() > 0) ? popped[0].idx : -1, 2);
    check("pop_empty", fifoCount, 0);
    check("hold_idx", cmdIdx, 2);
    check("hold_pos", cmdPos, 50);

    // three-cycle glitch on button 0
    sawHigh = 0;
    btn = 3'b001;
    repeat (3) begin
      step();
      if (dut.genBtn[0].uDebounce.stableLevel) sawHigh = 1;
    end
    btn = 3'b000;
    repeat (12) begin
      step();
      if (dut.genBtn[0].uDebounce.stableLevel) sawHigh = 1;
    end
    check("glitch_stable", 32'(sawHigh), 0);
    check("glitch_cmd", fifoCount, 0);

    // simultaneous press of all buttons
    popped.delete();
    bytePos = 8'd0;
    cmdReady = 1'b1;
    btn = 3'b111;
    step(14);
    btn = 3'b000;
    step(10);
    check("simul_n", popped.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("simul_idx", (popped.size() > i) ? popped[i].idx : -1, i);
      check("simul_pos", (popped.size() > i) ? popped[i].pos : -1, 0);
    end

    // fill, hold pending, overflow, drain
    cmdReady = 1'b0;
    press(0, 10);
    press(1, 11);
    press(2, 12);
    press(0, 13);
    press(1, 14);
    press(2, 15);
    check("full_count", fifoCount, 4);
    check("full_no_ovf", overflow, 0);
    press(1, 16);
    check("ovf_set", overflow, 1);
    popped.delete();
    bytePos = 8'd99;
    cmdReady = 1'b1;
    step(12);
    cmdReady = 1'b0;
    check("drain_n", popped.size(), 6);
    begin
      int expIdx[6] = '{0, 1, 2, 0, 1, 2};
      int expPos[6] = '{10, 11, 12, 13, 99, 99};
      for (int i = 0; i < 6; i++) begin
        check("drain_idx", (popped.size() > i) ? popped[i].idx : -1, expIdx[i]);
        check("drain_pos", (popped.size() > i) ? popped[i].pos : -1, expPos[i]);
      end
    end

    // asynchronous reset while two commands are queued
    press(0, 1);
    press(2, 2);
    check("pre_rst_count", fifoCount, 2);
    #2 rst = 1'b0;
    #1;
    check("async_count", fifoCount, 0);
    check("async_valid", cmdValid, 0);
    check("async_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    step(2);

    // randomized presses, glitches, back-pressure and positions
    for (int b = 0; b < NB; b++) holdLeft[b] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (holdLeft[b] == 0) begin
          btn[b] = 1'($urandom_range(0, 1));
          holdLeft[b] = $urandom_range(1, 12);
        end
        holdLeft[b]--;
      end
      bytePos = 8'($urandom);
      cmdReady = ($urandom_range(0, 3) != 0);
      step();
    end
    btn = 3'b000;
    cmdReady = 1'b1;
    step(25);
    check("random_drained", fifoCount, 0);

`ifdef BTN_AUTOREPEAT_EN
    // held button repeats every REP cycles
    popped.delete();
    btn = 3'b010;
    lat = 0;
    while (!dut.genBtn[1].uDebounce.stableLevel && lat < 20) begin
      step();
      lat++;
    end
    step(50);
    btn = 3'b000;
    step(15);
    idx1Cnt = 0;
    foreach (popped[i]) if (popped[i].idx == 1) idx1Cnt++;
    check("repeat_n", idx1Cnt, 3);
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
